// File: rtl/fab_gpio_int_ctrl_if.sv
// Register bus between the MSS-side master and the GPIO/interrupt controller.
// One-cycle write strobe, read strobe with registered read data.
interface fab_gpio_int_ctrl_if;
  logic        REG_WE;
  logic        REG_RE;
  logic [2:0]  REG_ADDR;
  logic [31:0] REG_WDATA;
  logic [31:0] REG_RDATA;

  modport master (
    output REG_WE,
    output REG_RE,
    output REG_ADDR,
    output REG_WDATA,
    input  REG_RDATA
  );

  modport slave (
    input  REG_WE,
    input  REG_RE,
    input  REG_ADDR,
    input  REG_WDATA,
    output REG_RDATA
  );
endinterface

// File: rtl/fab_gpio_int_ctrl.sv
// Fabric GPIO/interrupt controller: synchronise + debounce pin inputs, detect
// per-channel events into W1C status, fold enabled status onto interrupt lines.
module fab_gpio_int_ctrl #(
  parameter int NUM_CH       = 2,
  parameter int NUM_INT      = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                FAB_CCC_GL0,
  input  logic                FAB_RESET_N,
  input  logic [NUM_CH-1:0]   GPIO_IN,
  fab_gpio_int_ctrl_if.slave  reg_bus,
  output logic [NUM_CH-1:0]   GPIO_OUT,
  output logic [NUM_INT-1:0]  INT
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  localparam logic [2:0] A_IE      = 3'd0;
  localparam logic [2:0] A_MODE_LO = 3'd1;
  localparam logic [2:0] A_MODE_HI = 3'd2;
  localparam logic [2:0] A_STATUS  = 3'd3;
  localparam logic [2:0] A_VAL     = 3'd4;
  localparam logic [2:0] A_OUT     = 3'd5;

  logic [NUM_CH-1:0]  sync_1, sync_2;
  logic [NUM_CH-1:0]  filt, filt_d;
  logic [CW-1:0]      cnt [NUM_CH];
  logic [NUM_CH-1:0]  ie, mode_lo, mode_hi, status, out_q;
  logic [NUM_INT-1:0] int_q;

  logic [NUM_CH-1:0]  evt, w1c, status_nxt, wr_data, rd_sel;
  logic [NUM_INT-1:0] int_nxt;
  logic [31:0]        rd_word;

  assign wr_data  = reg_bus.REG_WDATA[NUM_CH-1:0];
  assign GPIO_OUT = out_q;
  assign INT      = int_q;

  // Events compare the filtered value against its one-cycle-old copy.
  always_comb begin
    evt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case ({mode_hi[i], mode_lo[i]})
        2'b00:   evt[i] = filt[i] & ~filt_d[i];
        2'b01:   evt[i] = ~filt[i] & filt_d[i];
        2'b10:   evt[i] = filt[i] ^ filt_d[i];
        default: evt[i] = filt[i];
      endcase
    end
  end

  // A set event on the same edge as a W1C wins.
  always_comb begin
    w1c = '0;
    if (reg_bus.REG_WE && reg_bus.REG_ADDR == A_STATUS) w1c = wr_data;
    status_nxt = (status & ~w1c) | (evt & ie);
  end

  always_comb begin
    int_nxt = '0;
    for (int k = 0; k < NUM_INT; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i % NUM_INT == k) int_nxt[k] = int_nxt[k] | (status[i] & ie[i]);
      end
    end
  end

  always_comb begin
    case (reg_bus.REG_ADDR)
      A_IE:      rd_sel = ie;
      A_MODE_LO: rd_sel = mode_lo;
      A_MODE_HI: rd_sel = mode_hi;
      A_STATUS:  rd_sel = status;
      A_VAL:     rd_sel = filt;
      A_OUT:     rd_sel = out_q;
      default:   rd_sel = '0;
    endcase
    rd_word = '0;
    rd_word[NUM_CH-1:0] = rd_sel;
  end

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      sync_1 <= '0;
      sync_2 <= '0;
      filt   <= '0;
      filt_d <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      sync_1 <= GPIO_IN;
      sync_2 <= sync_1;
      filt_d <= filt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_2[i] != filt[i]) begin
          if (cnt[i] == CNT_LAST) begin
            filt[i] <= sync_2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i]  <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      ie                <= '0;
      mode_lo           <= '0;
      mode_hi           <= '0;
      status            <= '0;
      out_q             <= '0;
      int_q             <= '0;
      reg_bus.REG_RDATA <= '0;
    end else begin
      status <= status_nxt;
      int_q  <= int_nxt;
      if (reg_bus.REG_WE) begin
        case (reg_bus.REG_ADDR)
          A_IE:      ie      <= wr_data;
          A_MODE_LO: mode_lo <= wr_data;
          A_MODE_HI: mode_hi <= wr_data;
          A_OUT:     out_q   <= wr_data;
          default:   ;
        endcase
      end
      // Read mux sees pre-write register values when WE and RE coincide.
      if (reg_bus.REG_RE) reg_bus.REG_RDATA <= rd_word;
    end
  end

endmodule

// File: tb/tb_fab_gpio_int_ctrl.sv
// Directed bench for fab_gpio_int_ctrl: a default 2-channel instance and a
// 5-channel / 2-interrupt instance for routing, sharing clock and reset.
module tb_fab_gpio_int_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] gpio0, gout0, int0;
  logic [4:0] gpio1, gout1;
  logic [1:0] int1;
  logic [31:0] d;
  int n_cmp;
  int n_bad;

  fab_gpio_int_ctrl_if bus0 ();
  fab_gpio_int_ctrl_if bus1 ();

  fab_gpio_int_ctrl #(.NUM_CH(2), .NUM_INT(2), .DEBOUNCE_CYC(4)) dut0 (
    .FAB_CCC_GL0 (clk),
    .FAB_RESET_N (rst_n),
    .GPIO_IN     (gpio0),
    .reg_bus     (bus0.slave),
    .GPIO_OUT    (gout0),
    .INT         (int0)
  );

  fab_gpio_int_ctrl #(.NUM_CH(5), .NUM_INT(2), .DEBOUNCE_CYC(4)) dut1 (
    .FAB_CCC_GL0 (clk),
    .FAB_RESET_N (rst_n),
    .GPIO_IN     (gpio1),
    .reg_bus     (bus1.slave),
    .GPIO_OUT    (gout1),
    .INT         (int1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge.
  task automatic wr(input bit sel, input logic [2:0] a, input logic [31:0] v);
    if (sel) begin
      bus1.REG_WE = 1'b1; bus1.REG_ADDR = a; bus1.REG_WDATA = v;
    end else begin
      bus0.REG_WE = 1'b1; bus0.REG_ADDR = a; bus0.REG_WDATA = v;
    end
    @(negedge clk);
    bus0.REG_WE = 1'b0;
    bus1.REG_WE = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [2:0] a, output logic [31:0] v);
    if (sel) begin
      bus1.REG_RE = 1'b1; bus1.REG_ADDR = a;
    end else begin
      bus0.REG_RE = 1'b1; bus0.REG_ADDR = a;
    end
    @(negedge clk);
    bus0.REG_RE = 1'b0;
    bus1.REG_RE = 1'b0;
    v = sel ? bus1.REG_RDATA : bus0.REG_RDATA;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    gpio0 = 2'b11;
    gpio1 = '0;
    bus0.REG_WE = 1'b0; bus0.REG_RE = 1'b0; bus0.REG_ADDR = '0; bus0.REG_WDATA = '0;
    bus1.REG_WE = 1'b0; bus1.REG_RE = 1'b0; bus1.REG_ADDR = '0; bus1.REG_WDATA = '0;
    @(negedge clk);
    cyc(3);

    // Reset defaults with inputs high
    chk("rst_int0", 32'(int0), 32'h0);
    chk("rst_gout0", 32'(gout0), 32'h0);
    chk("rst_int1", 32'(int1), 32'h0);
    rd(0, 3'd4, d);
    chk("rst_read_val", d, 32'h0);

    rst_n = 1'b1;
    cyc(12);
    rd(0, 3'd3, d);
    chk("ie0_status", d, 32'h0);
    rd(0, 3'd4, d);
    chk("ie0_val_high", d, 32'h3);
    gpio0 = 2'b00;
    cyc(12);
    rd(0, 3'd4, d);
    chk("ie0_val_low", d, 32'h0);

    // Register width and unused addresses
    wr(0, 3'd0, 32'hFFFF_FFFF);
    rd(0, 3'd0, d);
    chk("ie_mask", d, 32'h3);
    wr(0, 3'd6, 32'hFFFF_FFFF);
    rd(0, 3'd6, d);
    chk("addr6_zero", d, 32'h0);
    rd(0, 3'd7, d);
    chk("addr7_zero", d, 32'h0);

    // Rising-edge latency on ch0: change sampled at edge t
    gpio0 = 2'b01;
    bus0.REG_RE = 1'b1;
    bus0.REG_ADDR = 3'd4;
    cyc(6);
    chk("val_before_t5", bus0.REG_RDATA, 32'h0);
    cyc(1);
    chk("val_after_t5", bus0.REG_RDATA, 32'h1);
    chk("int_t6", 32'(int0), 32'h0);
    cyc(1);
    chk("int_t7", 32'(int0), 32'h1);
    bus0.REG_RE = 1'b0;
    rd(0, 3'd3, d);
    chk("status_rise", d, 32'h1);
    wr(0, 3'd3, 32'h1);
    chk("int_at_w1c", 32'(int0), 32'h1);
    cyc(1);
    chk("int_after_w1c", 32'(int0), 32'h0);

    // 3-cycle glitch on ch1 is filtered
    gpio0 = 2'b11;
    cyc(3);
    gpio0 = 2'b01;
    cyc(12);
    rd(0, 3'd4, d);
    chk("glitch_val", d, 32'h1);
    rd(0, 3'd3, d);
    chk("glitch_status", d, 32'h0);
    chk("glitch_int", 32'(int0), 32'h0);

    // 4-cycle pulse on ch1 in either-edge mode: rise and fall both seen
    wr(0, 3'd2, 32'h2);
    gpio0 = 2'b11;
    cyc(4);
    gpio0 = 2'b01;
    cyc(4);
    chk("both_rise_int", 32'(int0), 32'h2);
    wr(0, 3'd3, 32'h2);
    cyc(1);
    chk("both_cleared_int", 32'(int0), 32'h0);
    cyc(2);
    chk("both_fall_int", 32'(int0), 32'h2);
    rd(0, 3'd4, d);
    chk("both_val", d, 32'h1);
    wr(0, 3'd3, 32'h2);

    // Level-high mode on ch0
    wr(0, 3'd2, 32'h3);
    wr(0, 3'd1, 32'h1);
    cyc(2);
    rd(0, 3'd3, d);
    chk("lvl_set", d, 32'h1);
    wr(0, 3'd3, 32'h1);
    rd(0, 3'd3, d);
    chk("lvl_w1c_high", d, 32'h1);
    gpio0 = 2'b00;
    cyc(12);
    wr(0, 3'd3, 32'h1);
    rd(0, 3'd3, d);
    chk("lvl_w1c_low", d, 32'h0);
    cyc(1);
    chk("lvl_int_low", 32'(int0), 32'h0);
    wr(0, 3'd2, 32'h2);
    wr(0, 3'd1, 32'h0);

    // W1C on the same edge as a new rising event
    gpio0 = 2'b01;
    cyc(6);
    wr(0, 3'd3, 32'h1);
    chk("coll_int_t6", 32'(int0), 32'h0);
    cyc(1);
    chk("coll_int_t7", 32'(int0), 32'h1);
    rd(0, 3'd3, d);
    chk("coll_status", d, 32'h1);
    chk("coll_int_hold", 32'(int0), 32'h1);

    // Clearing IE gates INT but keeps STATUS
    wr(0, 3'd0, 32'h0);
    chk("ie_off_int_w", 32'(int0), 32'h1);
    cyc(1);
    chk("ie_off_int_w1", 32'(int0), 32'h0);
    rd(0, 3'd3, d);
    chk("ie_off_status", d, 32'h1);
    wr(0, 3'd3, 32'h3);
    wr(0, 3'd0, 32'h3);

    // Output bank and read-during-write
    wr(0, 3'd5, 32'h2);
    chk("gout_write", 32'(gout0), 32'h2);
    bus0.REG_WE = 1'b1;
    bus0.REG_RE = 1'b1;
    bus0.REG_ADDR = 3'd5;
    bus0.REG_WDATA = 32'h1;
    cyc(1);
    bus0.REG_WE = 1'b0;
    bus0.REG_RE = 1'b0;
    chk("rdw_pre_value", bus0.REG_RDATA, 32'h2);
    chk("rdw_gout", 32'(gout0), 32'h1);
    rd(0, 3'd5, d);
    chk("rdw_readback", d, 32'h1);

    // Routing on the 5-channel instance: ch1 and ch3 both land on INT[1]
    wr(1, 3'd0, 32'h1F);
    gpio1 = 5'b01010;
    cyc(12);
    chk("route_both", 32'(int1), 32'h2);
    wr(1, 3'd3, 32'h2);
    cyc(2);
    chk("route_keep", 32'(int1), 32'h2);
    rd(1, 3'd3, d);
    chk("route_status", d, 32'h8);
    wr(1, 3'd3, 32'h8);
    cyc(1);
    chk("route_clear", 32'(int1), 32'h0);

    // Reset in the middle of a debounce window
    gpio1 = 5'b01011;
    cyc(3);
    rst_n = 1'b0;
    gpio1 = 5'b00000;
    cyc(1);
    chk("midrst_int1", 32'(int1), 32'h0);
    chk("midrst_gout0", 32'(gout0), 32'h0);
    rst_n = 1'b1;
    cyc(12);
    rd(1, 3'd3, d);
    chk("midrst_status", d, 32'h0);
    rd(1, 3'd4, d);
    chk("midrst_val", d, 32'h0);
    chk("midrst_int1_late", 32'(int1), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fab_gpio_int_ctrl.md
# fab_gpio_int_ctrl

Parametrised fabric GPIO/interrupt controller between the device pins and the MSS fabric-interrupt inputs. It synchronises and debounces NUM_CH GPIO inputs and detects a per-channel programmable event (rising, falling, both edges, level-high). It latches each event in a write-1-to-clear status register and aggregates enabled status bits onto NUM_INT interrupt lines. It also provides a register-driven GPIO output bank, replacing the fixed 2-bit GPIO/INT wiring of the current fabric top.

## Interface
- NUM_CH, default 2: GPIO channels, 1..32.
- NUM_INT, default 2: interrupt outputs, 1..16; channel i routes to INT[i mod NUM_INT].
- DEBOUNCE_CYC, default 4: consecutive clock edges with a stable differing input before the filtered value updates, 1..65535.
- FAB_CCC_GL0  in  1  fabric clock; all state on rising edge.
- FAB_RESET_N  in  1  asynchronous active-low reset; one clock, asynchronous active-low reset, fixed.
- GPIO_IN  in  NUM_CH  asynchronous pin inputs.
- REG_WE  in  1  register write strobe, one cycle per write.
- REG_RE  in  1  register read strobe.
- REG_ADDR  in  3  register index.
- REG_WDATA  in  32  write data; bits above NUM_CH ignored.
- REG_RDATA  out  32  read data, registered; bits above NUM_CH read 0.
- GPIO_OUT  out  NUM_CH  output bank.
- INT  out  NUM_INT  level interrupts to MSS, registered.

## Operation
- Registers (addr: name, access):
  - 0: IE, RW.
  - 1: MODE_LO, RW.
  - 2: MODE_HI, RW.
  - 3: STATUS, R/W1C.
  - 4: GPIO_VAL, RO (filtered inputs).
  - 5: OUT, RW (drives GPIO_OUT).
  - 6–7: read 0, writes ignored.
- Per-channel mode {MODE_HI[i],MODE_LO[i]}:
  - 00: rising edge of the filtered value.
  - 01: falling edge.
  - 10: either edge.
  - 11: level-high; STATUS[i] set every cycle the filtered value is 1.
- Input path: 2-flop synchroniser per channel, then debounce.
- Debounce: per-channel counter (ceil(log2(DEBOUNCE_CYC+1)) bits).
  - Counter increments on each edge where the synchronised value ≠ filtered value.
  - Counter clears on any edge where they are equal.
  - On the DEBOUNCE_CYC-th consecutive mismatching edge, the filtered value takes the synchronised value and the counter clears.
- STATUS[i] sets only when IE[i]=1 and the mode's event occurs. Clearing IE does not clear existing STATUS.
- Writing 1 to STATUS[i] clears it; writing 0 has no effect. On a simultaneous set event and W1C on the same bit, the set wins.
- INT[k] = registered OR over channels i with i mod NUM_INT = k of (STATUS[i] & IE[i]).
- Reads: REG_RE samples REG_ADDR; REG_RDATA updates on the same edge and holds until the next REG_RE.
- REG_WE and REG_RE in the same cycle: the read returns the pre-write value.
- Reset: all registers, synchronisers, filters and counters are 0. GPIO_OUT=0, INT=0, REG_RDATA=0.
- An input already high at reset release produces a rising event after the filter latency, but only if IE is set by then.
- Reset asserted mid-debounce or mid-event: all state returns to 0 immediately; no event survives.

## Timing
- Input change sampled at edge t:
  - Synchroniser output valid after edge t+1.
  - Filtered value updates at edge t+1+DEBOUNCE_CYC.
  - STATUS sets at t+2+DEBOUNCE_CYC.
  - INT asserts at t+3+DEBOUNCE_CYC.
- A glitch shorter than DEBOUNCE_CYC cycles at the synchroniser output produces no event and no GPIO_VAL change.
- W1C at edge w clears STATUS at w; INT deasserts at w+1 unless another routed status bit is still set.
- OUT write at edge w drives GPIO_OUT from w.
- IE write at edge w affects events detected at w+1 onward and INT from w+1.
- Level mode: W1C while the level stays high has no lasting effect; STATUS re-sets the next edge.

## Test plan
- Reset defaults: hold FAB_RESET_N low with GPIO_IN=2'b11 -> INT=0, GPIO_OUT=0, all reads 0. Release with IE=0 -> STATUS stays 0.
- Rising edge latency, NUM_CH=2, DEBOUNCE_CYC=4: IE=1, MODE=00, GPIO_IN[0] 0->1 sampled at edge t -> GPIO_VAL[0]=1 at t+5, STATUS=0x1 at t+6, INT[0]=1 at t+7. Write STATUS=0x1 -> INT[0]=0 the next cycle.
- Glitch reject: 3-cycle pulse on GPIO_IN[1] with DEBOUNCE_CYC=4 -> GPIO_VAL, STATUS and INT unchanged. 4-cycle pulse -> both edges captured when MODE=10.
- Level mode: MODE_HI=MODE_LO=1 for ch0, input held high, W1C STATUS -> reads 1 again on the next read; input low then W1C -> stays 0.
- Set/clear collision: W1C STATUS[0] on the exact edge a new rising event sets it -> STATUS[0]=1 and INT stays asserted.
- Routing, NUM_CH=5, NUM_INT=2: events on ch1 and ch3 only -> INT=2'b10. Clear ch1 only -> INT[1] stays 1 until ch3 is cleared.
